octave_mode_ctrl: RTL
=====================

Name: octave_mode_ctrl

Overview:
- Consumes the one-cycle button pulses produced by the keypad edge-detect stage (mode, octave up, octave down).
- Holds the synth's current octave and waveform mode as registered state.
- Feeds the tone generator and the status LEDs.
- Provides saturating octave control, a cyclic waveform FSM, a change strobe, and a timed limit-hit flash.

Parameters:
- OCT_MIN, 0, lowest legal octave.
- OCT_MAX, 6, highest legal octave. Legal range is OCT_MIN <= OCT_RESET <= OCT_MAX <= 7.
- OCT_RESET, 3, octave value loaded at reset.
- FLASH_CYCLES, 1000000, number of cycles limit_flash stays high after a rejected octave step. Must be >= 1.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- modekey  input  1  one-cycle pulse: advance waveform mode
- octive_up  input  1  one-cycle pulse: octave +1
- octive_down  input  1  one-cycle pulse: octave -1
- hold  input  1  when high, all three pulses are ignored
- octave  output  3  current octave
- mode  output  2  current waveform: 00 square, 01 saw, 10 triangle, 11 sine
- update  output  1  one-cycle strobe; high in the first cycle a new octave and/or mode value is visible
- limit_flash  output  1  high while the limit-hit timer is running

Behaviour:
- Reset: clock is clk; reset is n_rst, asynchronous, active-low. While n_rst is low:
  - octave = OCT_RESET, mode = 00 (SQUARE)
  - update = 0, limit_flash = 0, flash counter = 0
- Inputs are sampled on posedge clk. Every output is a flop; no combinational path from input to output.
- Latency: a pulse sampled at edge N changes the outputs immediately after edge N, i.e. they are visible in cycle N+1.
- Hold: with hold=1, modekey, octive_up and octive_down have no effect. The flash counter still decrements.
- Mode FSM, 4 states, advanced by modekey:
  - SQUARE -> SAW -> TRIANGLE -> SINE -> SQUARE
  - mode output equals the state encoding.
- Octave step:
  - up only: octave < OCT_MAX -> octave+1; octave == OCT_MAX -> unchanged and a limit event.
  - down only: octave > OCT_MIN -> octave-1; octave == OCT_MIN -> unchanged and a limit event.
  - up and down in the same cycle: both ignored. No change, no limit event.
  - octave never leaves [OCT_MIN, OCT_MAX]. There is no wrap-around.
- Mode and octave are independent. modekey together with an octave pulse applies both in the same cycle.
- update: asserted for exactly one cycle when octave or mode actually changed on the previous edge.
  - Not asserted on a limit event, on cancelled simultaneous up+down, or during hold.
  - Back-to-back changes give back-to-back update cycles.
- Flash timer:
  - Counter width is ceil(log2(FLASH_CYCLES+1)).
  - A limit event loads FLASH_CYCLES. Otherwise, if the counter is nonzero, it decrements by 1.
  - limit_flash is registered and equals (next counter != 0), so it is high for exactly FLASH_CYCLES cycles starting the cycle after the event.
  - A new limit event while running reloads FLASH_CYCLES (retrigger extends the flash).
- Reset mid-operation: all state returns to reset values immediately, including an in-progress flash.
- Pulse inputs are assumed one-cycle wide. A pulse held high for k cycles is treated as k steps; no extra filtering is done.

Test Plan:
- Reset with OCT_RESET=3 -> octave=3, mode=00, update=0, limit_flash=0; then 4 modekey pulses spaced 3 cycles apart -> mode 01, 10, 11, 00, each one cycle after its pulse, with update=1 for one cycle each time.
- From octave=3 with OCT_MAX=6, 5 consecutive octive_up pulses (one per cycle) -> octave 4, 5, 6, 6, 6; update high in 3 consecutive cycles only; limit_flash rises the cycle after the 4th pulse.
- With FLASH_CYCLES=4, one limit event at octave=OCT_MIN=0 -> limit_flash high for exactly 4 cycles; a second octive_down 2 cycles into the flash -> flash lasts 4 cycles from the second event (6 cycles total).
- octive_up and octive_down asserted together at octave=3 -> octave stays 3, update=0, limit_flash=0; same cycle with modekey -> mode advances, update=1, octave unchanged.
- hold=1 with all three pulses applied -> no output change, update=0; a flash already running keeps counting down to 0.
- n_rst asserted asynchronously mid-flash at octave=6, mode=10 -> outputs return to octave=3, mode=00, limit_flash=0 before the next clk edge.

Source files
------------

// File: rtl/octave_mode_if.sv
// Keypad-to-synth control bus: button pulses in, octave/mode/status out.
interface octave_mode_if;
    logic       modekey;
    logic       octive_up;
    logic       octive_down;
    logic       hold;
    logic [2:0] octave;
    logic [1:0] mode;
    logic       update;
    logic       limit_flash;

    modport master (
        output modekey, octive_up, octive_down, hold,
        input  octave, mode, update, limit_flash
    );

    modport slave (
        input  modekey, octive_up, octive_down, hold,
        output octave, mode, update, limit_flash
    );
endinterface

// File: rtl/octave_mode_ctrl.sv
// Octave/waveform state for the synth: saturating octave, cyclic mode FSM,
// change strobe and a retriggerable limit-hit flash timer.
module octave_mode_ctrl #(
    parameter int OCT_MIN      = 0,
    parameter int OCT_MAX      = 6,
    parameter int OCT_RESET    = 3,
    parameter int FLASH_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         n_rst,
    octave_mode_if.slave bus
);
    localparam int CW = $clog2(FLASH_CYCLES + 1);
    localparam logic [2:0]    OMIN  = 3'(OCT_MIN);
    localparam logic [2:0]    OMAX  = 3'(OCT_MAX);
    localparam logic [2:0]    ORST  = 3'(OCT_RESET);
    localparam logic [CW-1:0] FLOAD = CW'(FLASH_CYCLES);

    typedef enum logic [1:0] {
        SQUARE   = 2'b00,
        SAW      = 2'b01,
        TRIANGLE = 2'b10,
        SINE     = 2'b11
    } mode_e;

    mode_e         mode_q, mode_d;
    logic [2:0]    oct_q, oct_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          upd_q, upd_d;
    logic          flash_q, flash_d;
    logic          limit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode_q  <= SQUARE;
            oct_q   <= ORST;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
            flash_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            oct_q   <= oct_d;
            cnt_q   <= cnt_d;
            upd_q   <= upd_d;
            flash_q <= flash_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        oct_d  = oct_q;
        limit  = 1'b0;
        if (!bus.hold) begin
            if (bus.modekey) begin
                unique case (mode_q)
                    SQUARE:   mode_d = SAW;
                    SAW:      mode_d = TRIANGLE;
                    TRIANGLE: mode_d = SINE;
                    SINE:     mode_d = SQUARE;
                    default:  mode_d = SQUARE;
                endcase
            end
            // Simultaneous up+down cancels out entirely.
            if (bus.octive_up && !bus.octive_down) begin
                if (oct_q < OMAX) oct_d = oct_q + 3'd1;
                else              limit = 1'b1;
            end else if (bus.octive_down && !bus.octive_up) begin
                if (oct_q > OMIN) oct_d = oct_q - 3'd1;
                else              limit = 1'b1;
            end
        end
        if (limit)             cnt_d = FLOAD;
        else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
        else                   cnt_d = cnt_q;
        upd_d   = (oct_d != oct_q) || (mode_d != mode_q);
        flash_d = (cnt_d != '0);
    end

    assign bus.octave      = oct_q;
    assign bus.mode        = mode_q;
    assign bus.update      = upd_q;
    assign bus.limit_flash = flash_q;
endmodule
